// File: rtl/deadtime_pkg.sv
// Shared types and constants for the multichannel dead-time generator.
// Optional feature macro: MIN_ON_TIME_EN (minimum conduction hold per channel).
package deadtime_pkg;

    // Per-channel leg state; the two DT_* states are the both-off dead-time intervals.
    typedef enum logic [2:0] {
        OFF,
        DT_TO_HIGH,
        HIGH,
        DT_TO_LOW,
        LOW
    } deadtime_state_t;

    // Smallest dead time ever applied; a programmed 0 is raised to this value.
    localparam int DT_MIN = 1;

endpackage

// File: rtl/deadtime_channel.sv
// One complementary leg: FSM, dead-time counter, optional min-on hold counter and
// registered gate outputs. Optional feature macro: MIN_ON_TIME_EN.
module deadtime_channel
    import deadtime_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     fault,
    input  logic [COUNTER_WIDTH-1:0] dt_rise,
    input  logic [COUNTER_WIDTH-1:0] dt_fall,
`ifdef MIN_ON_TIME_EN
    input  logic [COUNTER_WIDTH-1:0] min_on,
`endif
    input  logic                     pwm_in,
    output logic                     out_h,
    output logic                     out_l,
    output logic                     dt_active
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(DT_MIN);

    deadtime_state_t            state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   cnt_q, cnt_d;
    logic                       out_h_q, out_h_d;
    logic                       out_l_q, out_l_d;
    logic                       dt_active_q, dt_active_d;
    logic [COUNTER_WIDTH-1:0]   dt_rise_eff, dt_fall_eff;
    logic                       hold_done;

    // A programmed dead time of 0 still yields one both-off cycle.
    assign dt_rise_eff = (dt_rise == '0) ? CNT_ONE : dt_rise;
    assign dt_fall_eff = (dt_fall == '0) ? CNT_ONE : dt_fall;

`ifdef MIN_ON_TIME_EN
    logic [COUNTER_WIDTH-1:0] hold_q, hold_d;

    // The hold expires on the edge where the counter reaches 0, so a waiting request is taken then.
    assign hold_done = (hold_q <= CNT_ONE);

    // Hold counter: reload with min_on whenever HIGH or LOW is newly entered, else count down.
    always_comb begin
        hold_d = hold_q;
        if ((state_d == HIGH || state_d == LOW) && state_d != state_q) begin
            hold_d = min_on;
        end else if (hold_q != '0) begin
            hold_d = hold_q - CNT_ONE;
        end
    end

    // Hold counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_done = 1'b1;
`endif

    // State register, dead-time counter and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            out_h_q     <= 1'b0;
            out_l_q     <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_h_q     <= out_h_d;
            out_l_q     <= out_l_d;
            dt_active_q <= dt_active_d;
        end
    end

    // Next-state and counter logic: fault, then enable, then the normal leg sequence.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fault || !enable) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    if (pwm_in) begin
                        state_d = DT_TO_HIGH;
                        cnt_d   = dt_rise_eff;
                    end else begin
                        state_d = DT_TO_LOW;
                        cnt_d   = dt_fall_eff;
                    end
                end
                LOW: begin
                    if (pwm_in && hold_done) begin
                        state_d = DT_TO_HIGH;
                        cnt_d   = dt_rise_eff;
                    end
                end
                HIGH: begin
                    if (!pwm_in && hold_done) begin
                        state_d = DT_TO_LOW;
                        cnt_d   = dt_fall_eff;
                    end
                end
                DT_TO_HIGH: begin
                    if (!pwm_in) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                DT_TO_LOW: begin
                    if (pwm_in) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the gates change on the same edge as the state.
    always_comb begin
        out_h_d     = (state_d == HIGH);
        out_l_d     = (state_d == LOW);
        dt_active_d = (state_d == DT_TO_HIGH) || (state_d == DT_TO_LOW);
    end

    assign out_h     = out_h_q;
    assign out_l     = out_l_q;
    assign dt_active = dt_active_q;

endmodule

// File: rtl/multichannel_deadtime_gen.sv
// N-channel complementary dead-time inserter: one independent deadtime_channel per leg.
// Optional feature macro: MIN_ON_TIME_EN (adds the min_on port and per-channel hold).
module multichannel_deadtime_gen #(
    parameter int N_CHANNELS    = 3,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                fault,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] dt_rise,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] dt_fall,
`ifdef MIN_ON_TIME_EN
    input  logic [COUNTER_WIDTH-1:0]            min_on,
`endif
    input  logic [N_CHANNELS-1:0]               pwm_in,
    output logic [N_CHANNELS-1:0]               out_h,
    output logic [N_CHANNELS-1:0]               out_l,
    output logic [N_CHANNELS-1:0]               dt_active
);

    // One leg per channel; channel i takes its dead times from slice [i*CW +: CW].
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        deadtime_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_channel (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable),
            .fault     (fault),
            .dt_rise   (dt_rise[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .dt_fall   (dt_fall[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
`ifdef MIN_ON_TIME_EN
            .min_on    (min_on),
`endif
            .pwm_in    (pwm_in[i]),
            .out_h     (out_h[i]),
            .out_l     (out_l[i]),
            .dt_active (dt_active[i])
        );
    end

endmodule

// File: tb/tb_multichannel_deadtime_gen.sv
// Self-checking bench for multichannel_deadtime_gen (3 channels, 16-bit counters).
// Builds with or without MIN_ON_TIME_EN; the min-on expectations follow the macro.
module tb_multichannel_deadtime_gen;

    localparam int N  = 3;
    localparam int CW = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            fault;
    logic [N*CW-1:0] dt_rise;
    logic [N*CW-1:0] dt_fall;
`ifdef MIN_ON_TIME_EN
    logic [CW-1:0]   min_on;
`endif
    logic [N-1:0]    pwm_in;
    logic [N-1:0]    out_h;
    logic [N-1:0]    out_l;
    logic [N-1:0]    dt_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int overlap_cnt = 0;

    typedef struct {
        logic       fault;
        logic       enable;
        logic [2:0] pwm;
        logic [2:0] h;
        logic [2:0] l;
        logic [2:0] dt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   gap_rise_q[$];
    int   gap_fall_q[$];
    int   fall_cyc_q[$];

    multichannel_deadtime_gen #(
        .N_CHANNELS    (N),
        .COUNTER_WIDTH (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .fault     (fault),
        .dt_rise   (dt_rise),
        .dt_fall   (dt_fall),
`ifdef MIN_ON_TIME_EN
        .min_on    (min_on),
`endif
        .pwm_in    (pwm_in),
        .out_h     (out_h),
        .out_l     (out_l),
        .dt_active (dt_active)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Shoot-through monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (reset === 1'b1 && (out_h & out_l) != '0) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout cycles=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dt(input int ch, input int r, input int f);
        dt_rise[ch*CW +: CW] = CW'(r);
        dt_fall[ch*CW +: CW] = CW'(f);
    endtask

    function automatic void add(input logic f, input logic e, input logic [2:0] p,
                                input logic [2:0] h, input logic [2:0] l, input logic [2:0] dt);
        vec_t v;
        v.fault = f; v.enable = e; v.pwm = p; v.h = h; v.l = l; v.dt = dt;
        vecs.push_back(v);
    endfunction

    // Apply each queued vector before an edge; compare {out_h,out_l,dt_active} after it.
    task automatic run_vectors(input string tag);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            fault  = vecs[i].fault;
            enable = vecs[i].enable;
            pwm_in = vecs[i].pwm;
            exp_q.push_back(vecs[i]);
            tick();
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), {23'd0, out_h, out_l, dt_active},
                  {23'd0, e.h, e.l, e.dt});
        end
        vecs.delete();
    endtask

    initial begin
        int   t_lfall, t_hfall, t_fall, e_cyc, exp_gap, exp_fall;
        logic ph, pl, prev_p, p, found;
        logic pat [15];

        // ---------------- 1: reset and release ----------------
        reset  = 1'b0;
        enable = 1'b1;
        fault  = 1'b0;
        pwm_in = 3'b111;
        for (int ch = 0; ch < N; ch++) set_dt(ch, 5, 3);
`ifdef MIN_ON_TIME_EN
        min_on = '0;
`endif
        repeat (3) tick();
        check("reset_outputs", {23'd0, out_h, out_l, dt_active}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) add(0, 1, 3'b111, 3'b000, 3'b000, 3'b111);
        add(0, 1, 3'b111, 3'b111, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) add(0, 1, 3'b000, 3'b000, 3'b000, 3'b111);
        add(0, 1, 3'b000, 3'b000, 3'b111, 3'b000);
        add(0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) add(0, 1, 3'b000, 3'b000, 3'b000, 3'b111);
        add(0, 1, 3'b000, 3'b000, 3'b111, 3'b000);
        run_vectors("t1_release");

        // ---------------- 2: asymmetric dead times, 50-cycle square ----------------
        set_dt(0, 3, 7);
        t_lfall = -1000;
        t_hfall = -1000;
        ph      = out_h[0];
        pl      = out_l[0];
        prev_p  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            p = ((c / 25) % 2 == 0);
            if (p && !prev_p) gap_rise_q.push_back(3);
            if (!p && prev_p) gap_fall_q.push_back(7);
            prev_p = p;
            pwm_in = {2'b00, p};
            tick();
            if (pl && !out_l[0]) t_lfall = cyc;
            if (ph && !out_h[0]) t_hfall = cyc;
            if (!ph && out_h[0]) begin
                exp_gap = (gap_rise_q.size() > 0) ? gap_rise_q.pop_front() : -1;
                check("t2_gap_before_h", cyc - t_lfall, exp_gap);
            end
            if (!pl && out_l[0]) begin
                exp_gap = (gap_fall_q.size() > 0) ? gap_fall_q.pop_front() : -1;
                check("t2_gap_before_l", cyc - t_hfall, exp_gap);
            end
            ph = out_h[0];
            pl = out_l[0];
        end
        check("t2_pending_edges", gap_rise_q.size() + gap_fall_q.size(), 0);

        // ---------------- 3: abort of a pending rise ----------------
        set_dt(0, 10, 7);
        add(0, 1, 3'b000, 3'b000, 3'b111, 3'b000);
        add(0, 1, 3'b001, 3'b000, 3'b110, 3'b001);
        add(0, 1, 3'b001, 3'b000, 3'b110, 3'b001);
        add(0, 1, 3'b000, 3'b000, 3'b111, 3'b000);
        add(0, 1, 3'b000, 3'b000, 3'b111, 3'b000);
        run_vectors("t3_abort");

        // ---------------- 4: fault kill and recovery ----------------
        for (int ch = 0; ch < N; ch++) set_dt(ch, 4, 3);
        for (int i = 0; i < 4; i++) add(0, 1, 3'b111, 3'b000, 3'b000, 3'b111);
        add(0, 1, 3'b111, 3'b111, 3'b000, 3'b000);
        add(0, 1, 3'b111, 3'b111, 3'b000, 3'b000);
        add(1, 1, 3'b111, 3'b000, 3'b000, 3'b000);
        add(1, 1, 3'b111, 3'b000, 3'b000, 3'b000);
        add(1, 0, 3'b111, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++) add(0, 1, 3'b111, 3'b000, 3'b000, 3'b111);
        add(0, 1, 3'b111, 3'b111, 3'b000, 3'b000);
        run_vectors("t4_fault");

        // ---------------- 5: zero dead time, simultaneous edges ----------------
        set_dt(0, 2, 5);
        set_dt(1, 0, 0);
        set_dt(2, 6, 1);
        add(0, 1, 3'b000, 3'b000, 3'b000, 3'b111);
        for (int i = 0; i < 4; i++) add(0, 1, 3'b000, 3'b000, 3'b110, 3'b001);
        add(0, 1, 3'b000, 3'b000, 3'b111, 3'b000);
        add(0, 1, 3'b111, 3'b000, 3'b000, 3'b111);
        add(0, 1, 3'b111, 3'b010, 3'b000, 3'b101);
        for (int i = 0; i < 4; i++) add(0, 1, 3'b111, 3'b011, 3'b000, 3'b100);
        add(0, 1, 3'b111, 3'b111, 3'b000, 3'b000);
        run_vectors("t5_indep");

        // ---------------- 6: minimum on-time hold ----------------
        set_dt(0, 2, 7);
`ifdef MIN_ON_TIME_EN
        min_on = CW'(8);
`endif
        pwm_in = 3'b110;
        found  = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (out_l[0]) found = 1'b1;
        end
        check("t6_reach_low", found, 1);
        pwm_in = 3'b111;
        found  = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (out_h[0]) found = 1'b1;
        end
        check("t6_reach_high", found, 1);
        e_cyc = cyc;
`ifdef MIN_ON_TIME_EN
        fall_cyc_q.push_back(e_cyc + 8);
`else
        fall_cyc_q.push_back(e_cyc + 1);
`endif
        for (int k = 0; k < 15; k++) pat[k] = (k == 3 || k == 4);
        t_fall = -1;
        for (int k = 0; k < 15; k++) begin
            pwm_in = {2'b11, pat[k]};
            tick();
            if (t_fall < 0 && !out_h[0]) t_fall = cyc;
            if (k == 1) begin
`ifdef MIN_ON_TIME_EN
                check("t6_held_during_pulse", out_h[0], 1);
`else
                check("t6_pulse_taken", out_h[0], 0);
`endif
            end
        end
        exp_fall = fall_cyc_q.pop_front();
        check("t6_fall_cycle", t_fall, exp_fall);
        check("t6_final_low", out_l[0], 1);

        check("no_shoot_through", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
